// File: rtl/act_lut_pkg.sv
// rtl/act_lut_pkg.sv - shared types and constants for the activation lookup table
package act_lut_pkg;

  // Default table geometry, shared with the interpolating activation function
  localparam int ACT_ADDR_W = 4;
  localparam int ACT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    SWAP  = 2'd3
  } lut_state_t;

  // Segments plus the upper endpoint
  function automatic int lut_points(input int addr_w);
    return (1 << addr_w) + 1;
  endfunction

  localparam int LUT_POINTS = lut_points(ACT_ADDR_W);

endpackage

// File: rtl/act_lut_bank.sv
// rtl/act_lut_bank.sv - one breakpoint bank, one write port, reads at addr and addr+1
module act_lut_bank
  import act_lut_pkg::*;
#(
  parameter int ADDR_W = ACT_ADDR_W,
  parameter int DATA_W = ACT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W:0]          waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata_lo,
  output logic signed [DATA_W-1:0] rdata_hi
);

  localparam int NPTS = lut_points(ADDR_W);
  localparam logic [ADDR_W:0] LAST_IDX = {1'b1, {ADDR_W{1'b0}}};

  logic signed [DATA_W-1:0] mem [NPTS];
  logic [ADDR_W:0] raddr_lo;
  logic [ADDR_W:0] raddr_hi;

  // The upper read port never wraps: segment 2^ADDR_W-1 reads the endpoint
  assign raddr_lo = {1'b0, raddr};
  assign raddr_hi = raddr_lo + {{ADDR_W{1'b0}}, 1'b1};
  assign rdata_lo = mem[raddr_lo];
  assign rdata_hi = mem[raddr_hi];

  // Point storage, cleared to zero on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPTS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr <= LAST_IDX)) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/act_lut_loader.sv
// rtl/act_lut_loader.sv - double-buffered activation LUT loader (ACT_LUT_CHECKSUM_EN adds trailing checksum byte)
module act_lut_loader
  import act_lut_pkg::*;
#(
  parameter int ADDR_W = ACT_ADDR_W,
  parameter int DATA_W = ACT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     wr_valid,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next__data,
  output logic                     loading,
  output logic                     swap_done,
  output logic                     bank_sel,
  output logic                     crc_error
);

  localparam logic [ADDR_W:0] LAST_IDX = {1'b1, {ADDR_W{1'b0}}};

  lut_state_t state, state_nx;
  logic [ADDR_W:0] count;
  logic accept;
  logic load_beat;
  logic we0, we1;
  logic signed [DATA_W-1:0] base0, next0, base1, next1;

`ifdef ACT_LUT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_acc;
  logic [DATA_W-1:0] sum_nx;
  logic sum_ok;
  logic crc_q;

  assign sum_nx = sum_acc + wr_data;
  assign sum_ok = (sum_nx == '0);
`endif

  assign accept    = wr_valid && wr_ready;
  assign load_beat = accept && (state == LOAD);
  assign loading   = (state == LOAD) || (state == CHECK);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs; abort drops ready so no beat slips in
  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    swap_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        wr_ready = !abort;
        if (abort) begin
          state_nx = IDLE;
        end else if (wr_valid && (count == LAST_IDX)) begin
`ifdef ACT_LUT_CHECKSUM_EN
          state_nx = CHECK;
`else
          state_nx = SWAP;
`endif
        end
      end
      CHECK: begin
`ifdef ACT_LUT_CHECKSUM_EN
        wr_ready = !abort;
        if (abort) begin
          state_nx = IDLE;
        end else if (wr_valid) begin
          state_nx = sum_ok ? SWAP : IDLE;
        end
`else
        state_nx = IDLE;
`endif
      end
      SWAP: begin
        swap_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write counter and active-bank select; the bank flips as SWAP is left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      bank_sel <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        count <= '0;
      end else if (load_beat) begin
        count <= count + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (state == SWAP) begin
        bank_sel <= !bank_sel;
      end
    end
  end

`ifdef ACT_LUT_CHECKSUM_EN
  // Running byte sum of the points and the sticky mismatch flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_acc <= '0;
      crc_q   <= 1'b0;
    end else if ((state == IDLE) && start) begin
      sum_acc <= '0;
      crc_q   <= 1'b0;
    end else if (load_beat) begin
      sum_acc <= sum_nx;
    end else if (accept && (state == CHECK) && !sum_ok) begin
      crc_q <= 1'b1;
    end
  end

  assign crc_error = crc_q;
`else
  assign crc_error = 1'b0;
`endif

  // Only the inactive bank is ever written
  assign we0 = load_beat && bank_sel;
  assign we1 = load_beat && !bank_sel;

  act_lut_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .we       (we0),
    .waddr    (count),
    .wdata    (wr_data),
    .raddr    (address),
    .rdata_lo (base0),
    .rdata_hi (next0)
  );

  act_lut_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .we       (we1),
    .waddr    (count),
    .wdata    (wr_data),
    .raddr    (address),
    .rdata_lo (base1),
    .rdata_hi (next1)
  );

  assign base       = bank_sel ? base1 : base0;
  assign next__data = bank_sel ? next1 : next0;

endmodule

// File: doc/act_lut_loader.md
# act_lut_loader

Double-buffered, writable activation lookup table for the fixed-point neural network datapath. The host or a training controller streams a new set of signed 8-bit breakpoints into a shadow bank. The block then swaps banks atomically, so the activation unit always reads a complete, consistent table. The read side presents the same `address`/`base`/`next__data` contract that the interpolating activation function consumes. This block is the write end of that lookup interface.

## Interface
- `ADDR_W`, default 4: table address width. The table holds 2^ADDR_W segments.
- `DATA_W`, default 8: signed breakpoint width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load session. Sampled only in IDLE.
- `abort`  in  1  cancels an in-progress load session.
- `wr_valid`  in  1  write stream beat valid.
- `wr_data`  in  DATA_W signed  breakpoint value or checksum byte.
- `wr_ready`  out  1  write stream ready.
- `address`  in  ADDR_W  read segment index.
- `base`  out  DATA_W signed  active-bank entry at `address`.
- `next__data`  out  DATA_W signed  active-bank entry at `address+1`.
- `loading`  out  1  high in LOAD and CHECK.
- `swap_done`  out  1  one-cycle pulse; the new table becomes live on the next cycle.
- `bank_sel`  out  1  index of the active bank.
- `crc_error`  out  1  sticky checksum failure flag.

## Operation
- Each bank holds 2^ADDR_W+1 points (17 by default). The extra point is the upper endpoint, so `next__data` at address 15 is point 16. There is no wrap-around.
- The read path is purely combinational from the active bank and is never affected by shadow writes.
- FSM states: IDLE, LOAD, CHECK, SWAP.
- IDLE:
  - `wr_ready`=0.
  - `start`=1 moves to LOAD, clears the write counter and clears `crc_error`.
- LOAD:
  - `wr_ready` = !`abort`.
  - Each `wr_valid`&&`wr_ready` beat writes shadow[count] and increments count.
  - The beat with count==2^ADDR_W (the last point) moves to CHECK if the checksum is enabled, else to SWAP.
- CHECK: accepts exactly one checksum beat, then goes to SWAP or IDLE (see Configuration).
- SWAP:
  - `wr_ready`=0 and `swap_done`=1 for one cycle.
  - `bank_sel` toggles at the edge leaving SWAP, then the FSM returns to IDLE.
- `abort`:
  - In LOAD or CHECK, returns to IDLE at the next edge.
  - Any beat presented in the same cycle is not accepted, because `abort` forces `wr_ready` low.
  - The shadow contents are discarded; the active bank and `bank_sel` are unchanged.
- `start` outside IDLE is ignored. `abort` in IDLE or SWAP is ignored; a SWAP always completes.
- A stall (`wr_valid`=0) holds state indefinitely. There is no timeout.

## Timing
- Reset values:
  - FSM=IDLE, count=0, `bank_sel`=0.
  - Both banks all zero, so `base`=`next__data`=0.
  - `wr_ready`=0, `loading`=0, `swap_done`=0, `crc_error`=0.
- Reset asserted mid-load discards everything, including the previously active table.
- `start` at edge E gives `wr_ready`=1 from cycle E+1.
- A back-to-back stream of 17 beats with the checksum disabled:
  - the last beat is accepted at edge E+17;
  - `swap_done` is high in cycle E+18;
  - the new table is visible on `base` from cycle E+19.
- The minimum turnaround from `swap_done` to the next accepted `start` is 1 cycle (IDLE).

## Configuration
- Macro: `ACT_LUT_CHECKSUM_EN`.
- Defined:
  - after the last point, CHECK accepts one extra byte;
  - the 8-bit two's-complement sum of all points plus the checksum byte must equal 0 mod 256;
  - match goes to SWAP;
  - mismatch sets `crc_error`, goes to IDLE and does not swap.
- Undefined:
  - the CHECK state and checksum accumulator are absent;
  - the stream is exactly 2^ADDR_W+1 beats;
  - `crc_error` is tied to 0.

## Structure
- Shared package `act_lut_pkg` holds:
  - the state enum `lut_state_t` {IDLE, LOAD, CHECK, SWAP};
  - `LUT_POINTS` = 2^ADDR_W+1;
  - the default `ADDR_W`/`DATA_W` constants, shared with the activation function.
- One sub-module, `act_lut_bank`: a single register bank with one write port and two combinational read ports (addr, addr+1). It is instantiated twice. The top level holds the FSM, counter, checksum and bank select.

## Test plan
- Reset, then read `address`=3 -> `base`=0, `next__data`=0, `bank_sel`=0, `wr_ready`=0.
- Load points k*8-64 for k=0..16 with no stalls:
  - `swap_done` arrives 1 cycle after the last beat and `bank_sel`=1;
  - `address`=15 then gives `base`=56, `next__data`=64.
- Start a second load, assert `abort` after 5 beats with `wr_valid`=1 -> no beat accepted in the abort cycle, FSM returns to IDLE, the table is unchanged, `bank_sel` stays 1.
- With `ACT_LUT_CHECKSUM_EN`:
  - load 17 points all 0x01 plus checksum 0xEF -> swap occurs;
  - repeat with checksum 0xEE -> `crc_error`=1 and `bank_sel` is unchanged.
- Assert `rst` during LOAD beat 9 -> all outputs return to reset values immediately and both banks read zero.
- Random `wr_valid` stalls (50%) over a full load -> the final table is identical to the no-stall run, and `start` pulses during LOAD are ignored.
